result_fifo_bank: RTL and testbench

Bank of 27 small per-lane byte FIFOs between the PE cube result outputs and the write-back micro-controller. Each PE lane pushes its 8-bit result when valid. The controller drains the bank group by group via a per-lane read-enable vector and a 3-bit group select. The bank presents the selected 4-lane group as one 32-bit word aligned with the controller's write enable, and raises the all-lanes-have-data flag that starts a write-back block.

---
 rtl/result_pkg.sv | 21 ++
 rtl/result_lane_fifo.sv | 64 ++++++
 rtl/result_fifo_bank.sv | 74 +++++++
 tb/tb_result_fifo_bank.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_pkg.sv
// Shared constants, types and helpers for the PE result FIFO bank.
package result_pkg;

   localparam int LANES          = 27;
   localparam int DATA_W         = 8;
   localparam int FIFO_DEPTH     = 4;
   localparam int WORD_W         = 32;
   localparam int BYTES_PER_WORD = 4;
   localparam int GROUPS         = (LANES + BYTES_PER_WORD - 1) / BYTES_PER_WORD;

   // Per-lane single-cycle error indications, folded into sticky flags at the top.
   typedef struct packed {
      logic overflow;
      logic underflow;
   } lane_err_t;

   function automatic int group_base(input logic [2:0] sel);
      return int'(sel) * BYTES_PER_WORD;
   endfunction

endpackage

// File: rtl/result_lane_fifo.sv
// Single result lane: circular byte FIFO with occupancy count, head output
// register and combinational overflow/underflow pulses.
module result_lane_fifo
   import result_pkg::*;
#(
   parameter int DATA_W     = result_pkg::DATA_W,
   parameter int FIFO_DEPTH = result_pkg::FIFO_DEPTH
) (
   input  logic              iClk,
   input  logic              iRstN,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] out_byte,
   output logic              has_data,
   output lane_err_t         err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];

   logic pop_ok;
   logic push_ok;

   // A full lane still accepts a push when the same-cycle pop frees the head slot.
   assign pop_ok  = pop && (count != '0);
   assign push_ok = push && ((count != CNT_W'(FIFO_DEPTH)) || pop_ok);

   assign has_data      = (count != '0);
   assign err.overflow  = push && !push_ok;
   assign err.underflow = pop && !pop_ok;

   // NOTE: sequential state uses <= so every read in this block sees pre-edge values.
   always_ff @(posedge iClk) begin
      if (!iRstN) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         out_byte <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok) begin
            rd_ptr   <= rd_ptr + PTR_W'(1);
            out_byte <= mem[rd_ptr];
         end
         unique case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; count and pointers alone decide which entries are live.
   always_ff @(posedge iClk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/result_fifo_bank.sv
// Bank of per-lane result FIFOs with sticky error flags, all-lanes-ready flag
// and 4-lane group packing for the write-back controller.
module result_fifo_bank #(
   parameter int LANES      = result_pkg::LANES,
   parameter int DATA_W     = result_pkg::DATA_W,
   parameter int FIFO_DEPTH = result_pkg::FIFO_DEPTH,
   parameter int WORD_W     = result_pkg::WORD_W
) (
   input  logic                    iClk,
   input  logic                    iRstN,
   input  logic [LANES-1:0]        iResultValid,
   input  logic [LANES*DATA_W-1:0] iResultData,
   input  logic [LANES-1:0]        iResultRdEn,
   input  logic [2:0]              iResultFifoSel,
   output logic                    oAllResultFifoHasData,
   output logic [WORD_W-1:0]       oResultWord,
   output logic [LANES-1:0]        oOverflow,
   output logic [LANES-1:0]        oUnderflow
);

   import result_pkg::*;

   localparam int LANES_PER_WORD = WORD_W / DATA_W;
   localparam int N_GROUPS       = (LANES + LANES_PER_WORD - 1) / LANES_PER_WORD;

   logic [DATA_W-1:0] lane_byte [LANES];
   lane_err_t         lane_err  [LANES];
   logic [LANES-1:0]  lane_has;
   logic [LANES-1:0]  ovf_pulse;
   logic [LANES-1:0]  unf_pulse;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      result_lane_fifo #(
         .DATA_W     (DATA_W),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_lane (
         .iClk      (iClk),
         .iRstN     (iRstN),
         .push      (iResultValid[i]),
         .push_data (iResultData[i*DATA_W +: DATA_W]),
         .pop       (iResultRdEn[i]),
         .out_byte  (lane_byte[i]),
         .has_data  (lane_has[i]),
         .err       (lane_err[i])
      );
      assign ovf_pulse[i] = lane_err[i].overflow;
      assign unf_pulse[i] = lane_err[i].underflow;
   end

   always_ff @(posedge iClk) begin
      if (!iRstN) begin
         oOverflow  <= '0;
         oUnderflow <= '0;
      end else begin
         oOverflow  <= oOverflow | ovf_pulse;
         oUnderflow <= oUnderflow | unf_pulse;
      end
   end

   assign oAllResultFifoHasData = &lane_has;

   // Lanes past the last real lane (partial final group, sel beyond range) read as zero.
   always_comb begin
      // NOTE: default assigned first so no path through this block infers a latch.
      oResultWord = '0;
      if (int'(iResultFifoSel) < N_GROUPS) begin
         for (int k = 0; k < LANES_PER_WORD; k++) begin
            if (group_base(iResultFifoSel) + k < LANES)
               oResultWord[k*DATA_W +: DATA_W] = lane_byte[group_base(iResultFifoSel) + k];
         end
      end
   end

endmodule

// File: tb/tb_result_fifo_bank.sv
// Self-checking bench for result_fifo_bank: directed tables, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_result_fifo_bank;

   localparam int L     = 27;
   localparam int DW    = 8;
   localparam int DEPTH = 4;

   logic          iClk = 1'b0;
   logic          iRstN;
   logic [L-1:0]  iResultValid;
   logic [L*DW-1:0] iResultData;
   logic [L-1:0]  iResultRdEn;
   logic [2:0]    iResultFifoSel;
   logic          oAllResultFifoHasData;
   logic [31:0]   oResultWord;
   logic [L-1:0]  oOverflow;
   logic [L-1:0]  oUnderflow;

   result_fifo_bank dut (
      .iClk                  (iClk),
      .iRstN                 (iRstN),
      .iResultValid          (iResultValid),
      .iResultData           (iResultData),
      .iResultRdEn           (iResultRdEn),
      .iResultFifoSel        (iResultFifoSel),
      .oAllResultFifoHasData (oAllResultFifoHasData),
      .oResultWord           (oResultWord),
      .oOverflow             (oOverflow),
      .oUnderflow            (oUnderflow)
   );

   always #5 iClk = ~iClk;

   int checks = 0;
   int errors = 0;

   // Reference model: one queue per lane plus the visible output byte per lane.
   logic [7:0]   mq [L][$];
   logic [7:0]   m_out [L];
   logic [L-1:0] m_ovf;
   logic [L-1:0] m_unf;

   logic [31:0]  snap_word;
   logic         snap_all;
   logic [L-1:0] snap_ovf;
   logic [L-1:0] snap_unf;

   typedef struct {
      logic [L-1:0] rden;
      logic [2:0]   sel;
      logic [31:0]  exp_word;
      logic         exp_all;
   } vec_t;

   vec_t drain_tbl [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < L; i++) begin
         mq[i].delete();
         m_out[i] = 8'h00;
      end
      m_ovf = '0;
      m_unf = '0;
   endtask

   task automatic model_step(input logic [L-1:0] v, input logic [L*DW-1:0] d,
                             input logic [L-1:0] re, input logic rn);
      if (!rn) begin
         model_reset();
         return;
      end
      for (int i = 0; i < L; i++) begin
         bit popped = 1'b0;
         if (re[i]) begin
            if (mq[i].size() > 0) begin
               m_out[i] = mq[i].pop_front();
               popped   = 1'b1;
            end else begin
               m_unf[i] = 1'b1;
            end
         end
         if (v[i]) begin
            if (mq[i].size() < DEPTH) mq[i].push_back(d[i*DW +: DW]);
            else                      m_ovf[i] = 1'b1;
         end
         if (popped) begin end
      end
   endtask

   function automatic logic [31:0] model_word(input logic [2:0] s);
      logic [31:0] w = '0;
      if (s <= 3'd6) begin
         for (int k = 0; k < 4; k++) begin
            int lane = 4 * int'(s) + k;
            if (lane < L) w[8*k +: 8] = m_out[lane];
         end
      end
      return w;
   endfunction

   function automatic logic model_all();
      for (int i = 0; i < L; i++) if (mq[i].size() == 0) return 1'b0;
      return 1'b1;
   endfunction

   // Drive one cycle's inputs, compare at the falling edge, then advance the model.
   task automatic cycle(input logic [L-1:0] v, input logic [L*DW-1:0] d,
                        input logic [L-1:0] re, input logic [2:0] s, input logic rn);
      iResultValid   = v;
      iResultData    = d;
      iResultRdEn    = re;
      iResultFifoSel = s;
      iRstN          = rn;
      @(negedge iClk);
      snap_word = oResultWord;
      snap_all  = oAllResultFifoHasData;
      snap_ovf  = oOverflow;
      snap_unf  = oUnderflow;
      check("model_word", snap_word, model_word(s));
      check("model_all",  {31'd0, snap_all}, {31'd0, model_all()});
      check("model_ovf",  {5'd0, snap_ovf}, {5'd0, m_ovf});
      check("model_unf",  {5'd0, snap_unf}, {5'd0, m_unf});
      @(posedge iClk);
      model_step(v, d, re, rn);
      #1;
   endtask

   function automatic logic [L-1:0] grp_mask(input int g);
      logic [L+3:0] m = (L+4)'(4'hF) << (4 * g);
      return m[L-1:0];
   endfunction

   function automatic logic [L*DW-1:0] lane_data(input int lane, input logic [7:0] b);
      logic [L*DW-1:0] d = '0;
      d[lane*DW +: DW] = b;
      return d;
   endfunction

   logic [L*DW-1:0] fill_data;
   logic [L-1:0]    all_lanes;

   task automatic fill_all();
      cycle(all_lanes, fill_data, '0, 3'd0, 1'b1);
      check("fill_pre_all", {31'd0, snap_all}, 32'd0);
   endtask

   task automatic run_drain(input int rows);
      for (int j = 0; j < rows; j++) begin
         cycle('0, '0, drain_tbl[j].rden, drain_tbl[j].sel, 1'b1);
         check($sformatf("drain_word_%0d", j), snap_word, drain_tbl[j].exp_word);
         check($sformatf("drain_all_%0d", j), {31'd0, snap_all}, {31'd0, drain_tbl[j].exp_all});
      end
   endtask

   initial begin
      logic [31:0] exp_words [7];
      exp_words = '{32'hA3A2A1A0, 32'hA7A6A5A4, 32'hABAAA9A8, 32'hAFAEADAC,
                    32'hB3B2B1B0, 32'hB7B6B5B4, 32'h00BAB9B8};
      for (int j = 0; j < 9; j++) begin
         drain_tbl[j].rden     = (j < 7) ? grp_mask(j) : '0;
         drain_tbl[j].sel      = (j == 0) ? 3'd0 : ((j == 8) ? 3'd6 : 3'(j - 1));
         drain_tbl[j].exp_word = (j == 0) ? 32'h0 : exp_words[(j == 8) ? 6 : j - 1];
         drain_tbl[j].exp_all  = (j == 0);
      end
      all_lanes = '1;
      for (int i = 0; i < L; i++) fill_data[i*DW +: DW] = 8'hA0 + 8'(i);

      iResultValid = '0; iResultData = '0; iResultRdEn = '0; iResultFifoSel = '0; iRstN = 1'b0;
      @(posedge iClk); @(posedge iClk); #1;
      model_reset();

      // Reset state for every select value, including the out-of-range one.
      for (int s = 0; s < 8; s++) begin
         cycle('0, '0, '0, 3'(s), 1'b0);
         check($sformatf("reset_word_sel%0d", s), snap_word, 32'h0);
      end

      // Fill every lane once, then drain in controller order.
      fill_all();
      run_drain(9);
      cycle('0, '0, '0, 3'd7, 1'b1);
      check("drain_sel7", snap_word, 32'h0);
      check("drain_done_all", {31'd0, snap_all}, 32'd0);
      check("drain_flags", {5'd0, snap_ovf | snap_unf}, 32'd0);

      // Overflow: five pushes into a depth-4 lane.
      cycle('0, '0, '0, 3'd0, 1'b0);
      for (int n = 1; n <= 5; n++) cycle(27'h1, lane_data(0, 8'(n)), '0, 3'd0, 1'b1);
      cycle('0, '0, '0, 3'd0, 1'b1);
      check("ovf_lane0", {5'd0, snap_ovf}, 32'h1);
      for (int n = 1; n <= 5; n++) begin
         cycle('0, '0, 27'h1, 3'd0, 1'b1);
         cycle('0, '0, '0, 3'd0, 1'b1);
         check($sformatf("ovf_pop_%0d", n), {24'd0, snap_word[7:0]}, (n <= 4) ? n : 4);
      end
      check("ovf_count4_unf", {5'd0, snap_unf}, 32'h1);

      // Full lane with simultaneous push and pop.
      cycle('0, '0, '0, 3'd0, 1'b0);
      for (int n = 0; n < 4; n++) cycle(27'h1, lane_data(0, 8'h11 + 8'(n)), '0, 3'd0, 1'b1);
      cycle(27'h1, lane_data(0, 8'h15), 27'h1, 3'd0, 1'b1);
      cycle('0, '0, '0, 3'd0, 1'b1);
      check("full_pp_ovf", {5'd0, snap_ovf}, 32'h0);
      check("full_pp_head", {24'd0, snap_word[7:0]}, 32'h11);
      for (int n = 0; n < 5; n++) begin
         cycle('0, '0, 27'h1, 3'd0, 1'b1);
         cycle('0, '0, '0, 3'd0, 1'b1);
         check($sformatf("full_pp_pop_%0d", n), {24'd0, snap_word[7:0]}, (n < 4) ? 32'h12 + n : 32'h15);
      end
      check("full_pp_count4", {5'd0, snap_unf}, 32'h1);

      // Underflow on empty lane 3 with a same-cycle push.
      cycle('0, '0, '0, 3'd0, 1'b0);
      cycle(27'h8, lane_data(3, 8'h77), 27'h8, 3'd0, 1'b1);
      cycle('0, '0, '0, 3'd0, 1'b1);
      check("unf_lane3", {5'd0, snap_unf}, 32'h8);
      check("unf_outreg_held", snap_word, 32'h0);
      cycle('0, '0, 27'h8, 3'd0, 1'b1);
      cycle('0, '0, '0, 3'd0, 1'b1);
      check("unf_push_kept", snap_word, 32'h77000000);
      check("unf_no_new_unf", {5'd0, snap_unf}, 32'h8);

      // Reset in the middle of a drain, then refill.
      cycle('0, '0, '0, 3'd0, 1'b0);
      cycle('0, '0, 27'h20, 3'd0, 1'b1);
      fill_all();
      run_drain(3);
      cycle('0, '0, grp_mask(3), 3'd2, 1'b0);
      cycle('0, '0, '0, 3'd3, 1'b1);
      check("mid_rst_word", snap_word, 32'h0);
      check("mid_rst_all", {31'd0, snap_all}, 32'd0);
      check("mid_rst_flags", {5'd0, snap_ovf | snap_unf}, 32'd0);
      fill_all();
      cycle('0, '0, '0, 3'd0, 1'b1);
      check("refill_all", {31'd0, snap_all}, 32'd1);
      check("refill_flags", {5'd0, snap_ovf | snap_unf}, 32'd0);
      run_drain(9);

      // Randomized traffic against the model.
      for (int c = 0; c < 600; c++) begin
         logic [L-1:0]    v, re;
         logic [L*DW-1:0] d;
         for (int i = 0; i < L; i++) begin
            v[i]  = ($urandom_range(0, 99) < 45);
            re[i] = ($urandom_range(0, 99) < 40);
            d[i*DW +: DW] = 8'($urandom);
         end
         cycle(v, d, re, 3'($urandom_range(0, 7)), ($urandom_range(0, 99) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
